// File: rtl/grayscale_stream_ctrl.sv
// Frame controller: RGB565 pixel pairs in, 8-bit luma bytes packed four per word out,
// with a 2-entry output buffer and start/busy/done frame sequencing.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | accepting input pairs until pairsLeft reaches 0
// S_FLUSH | all pairs taken, draining the output buffer
// S_DONE  | one-cycle completion pulse
module grayscale_stream_ctrl #(
    parameter int CNT_W = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] pixelCount,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      inData,
    input  logic             inValid,
    output logic             inReady,
    output logic [31:0]      outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             outLast
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // Wire pixels arrive byte-swapped, so the fields straddle the two bytes.
    function automatic logic [7:0] to_gray(input logic [15:0] p);
        logic [15:0] r_t;
        logic [15:0] g_t;
        logic [15:0] b_t;
        r_t = (16'd54  * {11'd0, p[7:3]}) >> 5;
        g_t = (16'd183 * {10'd0, p[2:0], p[15:13]}) >> 6;
        b_t = (16'd19  * {11'd0, p[12:8]}) >> 5;
        return 8'(r_t + g_t + b_t);
    endfunction

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pairs_q, pairs_d;
    logic             half_q, half_d;
    logic [15:0]      pack_q, pack_d;
    logic [31:0]      buf0_q, buf0_d;
    logic [31:0]      buf1_q, buf1_d;
    logic             last0_q, last0_d;
    logic             last1_q, last1_d;
    logic [1:0]       cnt_q, cnt_d;

    logic [CNT_W-1:0] pairs_start;
    logic [7:0]       gray_a;
    logic [7:0]       gray_b;
    logic             last_pair;
    logic             accept;
    logic             push;
    logic             pop;
    logic [31:0]      push_word;

    assign pairs_start = pixelCount >> 1;
    assign gray_a      = to_gray(inData[31:16]);
    assign gray_b      = to_gray(inData[15:0]);
    assign last_pair   = (pairs_q == CNT_W'(1));

    assign inReady   = (state_q == S_RUN) && (pairs_q != '0) && (cnt_q != 2'd2);
    assign accept    = inValid && inReady;
    assign push      = accept && (half_q || last_pair);
    assign pop       = (cnt_q != 2'd0) && outReady;
    assign push_word = half_q ? {gray_b, gray_a, pack_q} : {16'h0000, gray_b, gray_a};

    always_comb begin
        state_d = state_q;
        pairs_d = pairs_q;
        half_d  = half_q;
        pack_d  = pack_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        cnt_d   = cnt_q;

        // The tail slot is kept zero while unoccupied so a pop leaves outData at 0.
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d  = push_word;
                    last0_d = last_pair;
                end else begin
                    buf1_d  = push_word;
                    last1_d = last_pair;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                last0_d = last1_q;
                buf1_d  = 32'h0;
                last1_d = 1'b0;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d  = push_word;
                    last0_d = last_pair;
                end else begin
                    buf0_d  = buf1_q;
                    last0_d = last1_q;
                    buf1_d  = push_word;
                    last1_d = last_pair;
                end
            end
            default: ;
        endcase

        if (accept) begin
            pairs_d = pairs_q - CNT_W'(1);
            if (!half_q && !last_pair) begin
                pack_d = {gray_b, gray_a};
                half_d = 1'b1;
            end else begin
                pack_d = 16'h0000;
                half_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pairs_d = pairs_start;
                    half_d  = 1'b0;
                    pack_d  = 16'h0000;
                    state_d = (pairs_start == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_pair) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt_d == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pairs_q <= '0;
            half_q  <= 1'b0;
            pack_q  <= 16'h0000;
            buf0_q  <= 32'h0;
            buf1_q  <= 32'h0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pairs_q <= pairs_d;
            half_q  <= half_d;
            pack_q  <= pack_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign outData  = buf0_q;
    assign outValid = (cnt_q != 2'd0);
    assign outLast  = last0_q;

endmodule
